// File: rtl/cpu_mem_pkg.sv
// Shared types and default sizing for the CPU memory bridge.
// Also holds the read FSM encoding and the write-buffer pointer-width helper.
package cpu_mem_pkg;

    localparam int DATA_W_DEF     = 32;
    localparam int ADDR_W_DEF     = 32;
    localparam int WBUF_DEPTH_DEF = 4;

    // One extra pointer bit separates full from empty when the index bits match.
    function automatic int ptr_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

    localparam int PTR_W_DEF = ptr_width(WBUF_DEPTH_DEF);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        RD_HIT   = 3'd1,
        RD_DRAIN = 3'd2,
        RD_REQ   = 3'd3,
        RD_WAIT  = 3'd4,
        RD_DONE  = 3'd5
    } rd_state_e;

endpackage

// File: rtl/cpu_mem_bridge_wbuf_fifo.sv
// Posted-write buffer: circular storage with full/empty flags and a
// parallel address lookup that returns the youngest matching entry.
module wbuf_fifo
    import cpu_mem_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DEPTH  = WBUF_DEPTH_DEF,
    parameter int PTR_W  = PTR_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_push,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [DATA_W-1:0] i_data,
    input  logic              i_pop,
    input  logic [ADDR_W-1:0] i_lookup_addr,
    output logic              o_full,
    output logic              o_empty,
    output logic [ADDR_W-1:0] o_head_addr,
    output logic [DATA_W-1:0] o_head_data,
    output logic              o_hit,
    output logic [DATA_W-1:0] o_hit_data
);

    localparam int AW = PTR_W - 1;

    logic [ADDR_W-1:0] r_addr [DEPTH];
    logic [DATA_W-1:0] r_data [DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [PTR_W-1:0]  w_count;
    logic [AW-1:0]     w_idx;
    logic              w_match;
    logic              w_pop;

    assign w_count     = r_wr_ptr - r_rd_ptr;
    assign o_empty     = (r_wr_ptr == r_rd_ptr);
    assign o_full      = (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]) && (r_wr_ptr[AW] != r_rd_ptr[AW]);
    assign o_head_addr = r_addr[r_rd_ptr[AW-1:0]];
    assign o_head_data = r_data[r_rd_ptr[AW-1:0]];
    assign w_pop       = i_pop & ~o_empty;

    // Pointer advance and entry storage.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_addr[i] <= '0;
                r_data[i] <= '0;
            end
        end else begin
            if (i_push) begin
                r_addr[r_wr_ptr[AW-1:0]] <= i_addr;
                r_data[r_wr_ptr[AW-1:0]] <= i_data;
                r_wr_ptr                 <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
        end
    end

    // Scan oldest to youngest so the last match seen is the youngest.
    always_comb begin
        o_hit      = 1'b0;
        o_hit_data = '0;
        w_idx      = '0;
        w_match    = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            w_idx      = r_rd_ptr[AW-1:0] + AW'(i);
            w_match    = (PTR_W'(i) < w_count) && (r_addr[w_idx] == i_lookup_addr);
            o_hit      = o_hit | w_match;
            o_hit_data = w_match ? r_data[w_idx] : o_hit_data;
        end
    end

endmodule

// File: rtl/cpu_mem_bridge.sv
// Bridge between the multi-cycle CPU memory port and a handshaked memory:
// posted writes, read forwarding from the write buffer, and ordered read misses.
module cpu_mem_bridge
    import cpu_mem_pkg::*;
#(
    parameter int DATA_W     = DATA_W_DEF,
    parameter int ADDR_W     = ADDR_W_DEF,
    parameter int WBUF_DEPTH = WBUF_DEPTH_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              MemRead,
    input  logic              MemWrite,
    input  logic [ADDR_W-1:0] MemoryAddress,
    input  logic [DATA_W-1:0] WriteDataMem,
    output logic [DATA_W-1:0] MemoryOut,
    output logic              Stall,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ready,
    input  logic              mem_rvalid,
    input  logic [DATA_W-1:0] mem_rdata
);

    rd_state_e         r_state;
    rd_state_e         w_state_next;
    logic              w_full;
    logic              w_empty;
    logic              w_hit;
    logic [DATA_W-1:0] w_hit_data;
    logic [ADDR_W-1:0] w_head_addr;
    logic [DATA_W-1:0] w_head_data;
    logic              w_rd_req;
    logic              w_push;
    logic              w_pop;
    logic              w_wr_inflight;
    logic              w_port_owned;
    logic              w_rd_issue;
    logic              w_wr_issue;
    logic [ADDR_W-1:0] w_wr_addr;
    logic [DATA_W-1:0] w_wr_data;
    logic              r_mem_req;
    logic              r_mem_we;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [DATA_W-1:0] r_mem_wdata;
    logic [DATA_W-1:0] r_mem_out;

    // A simultaneous read and write is handled as a write only.
    assign w_rd_req      = MemRead & ~MemWrite;
    assign w_push        = MemWrite & ~w_full;
    assign w_wr_inflight = r_mem_req & r_mem_we;
    assign w_pop         = w_wr_inflight & mem_ready;
    assign w_port_owned  = (r_state == RD_REQ) || (r_state == RD_WAIT);
    assign w_rd_issue    = (w_state_next == RD_REQ) && (r_state != RD_REQ);
    assign w_wr_issue    = ~r_mem_req & ~w_port_owned & (~w_empty | w_push);
    // An empty buffer being pushed issues the incoming write directly.
    assign w_wr_addr     = w_empty ? MemoryAddress : w_head_addr;
    assign w_wr_data     = w_empty ? WriteDataMem  : w_head_data;

    assign mem_req   = r_mem_req;
    assign mem_we    = r_mem_we;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign MemoryOut = r_mem_out;

    wbuf_fifo #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .DEPTH  (WBUF_DEPTH),
        .PTR_W  (ptr_width(WBUF_DEPTH))
    ) u_wbuf (
        .clk           (clk),
        .rst           (rst),
        .i_push        (w_push),
        .i_addr        (MemoryAddress),
        .i_data        (WriteDataMem),
        .i_pop         (w_pop),
        .i_lookup_addr (MemoryAddress),
        .o_full        (w_full),
        .o_empty       (w_empty),
        .o_head_addr   (w_head_addr),
        .o_head_data   (w_head_data),
        .o_hit         (w_hit),
        .o_hit_data    (w_hit_data)
    );

    // Read FSM state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Read FSM next-state logic.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE: begin
                if (!w_rd_req) begin
                    w_state_next = IDLE;
                end else if (w_hit) begin
                    w_state_next = RD_HIT;
                end else if (w_empty && !w_wr_inflight) begin
                    w_state_next = RD_REQ;
                end else begin
                    w_state_next = RD_DRAIN;
                end
            end
            RD_HIT:  w_state_next = RD_DONE;
            RD_DRAIN: begin
                if (w_empty && !w_wr_inflight) begin
                    w_state_next = RD_REQ;
                end else begin
                    w_state_next = RD_DRAIN;
                end
            end
            RD_REQ: begin
                if (mem_ready) begin
                    w_state_next = RD_WAIT;
                end else begin
                    w_state_next = RD_REQ;
                end
            end
            RD_WAIT: begin
                if (mem_rvalid) begin
                    w_state_next = RD_DONE;
                end else begin
                    w_state_next = RD_WAIT;
                end
            end
            RD_DONE: w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    // CPU-facing stall output.
    always_comb begin
        Stall = (w_rd_req && (r_state != RD_DONE)) || (MemWrite && w_full);
    end

    // Memory request register: a request holds until mem_ready, then the port frees for a cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
        end else if (w_rd_issue) begin
            r_mem_req  <= 1'b1;
            r_mem_we   <= 1'b0;
            r_mem_addr <= MemoryAddress;
        end else if (w_wr_issue) begin
            r_mem_req   <= 1'b1;
            r_mem_we    <= 1'b1;
            r_mem_addr  <= w_wr_addr;
            r_mem_wdata <= w_wr_data;
        end else if (mem_ready) begin
            r_mem_req <= 1'b0;
        end
    end

    // Read data capture from either a buffer hit or the memory response.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_mem_out <= '0;
        end else if ((r_state == IDLE) && (w_state_next == RD_HIT)) begin
            r_mem_out <= w_hit_data;
        end else if ((r_state == RD_WAIT) && mem_rvalid) begin
            r_mem_out <= mem_rdata;
        end
    end

endmodule

// File: doc/cpu_mem_bridge.md
# cpu_mem_bridge

Parametrised memory-access bridge between the multi-cycle CPU's single memory port and a variable-latency memory with a request/ready handshake. It posts CPU writes into a WBUF_DEPTH-entry write buffer, forwards buffered data to matching reads, and keeps reads ordered behind pending writes. It drives a Stall line that the multi-cycle controller uses to hold its current state. It sits between the CPU top and the memory model, replacing the zero-wait direct connection.

## Interface
- DATA_W, 32, data word width
- ADDR_W, 32, address width; whole-word accesses only
- WBUF_DEPTH, 4, write-buffer entries; power of 2, ≥2
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-low
- MemRead  in  1  CPU read request; held until Stall=0
- MemWrite  in  1  CPU write request; held until Stall=0
- MemoryAddress  in  ADDR_W  CPU address
- WriteDataMem  in  DATA_W  CPU write data
- MemoryOut  out  DATA_W  read data to CPU; valid in the cycle MemRead=1 and Stall=0
- Stall  out  1  CPU must hold state and request
- mem_req  out  1  memory request; held with mem_we, mem_addr and mem_wdata stable until mem_ready
- mem_we  out  1  1=write, 0=read
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_ready  in  1  request accepted this cycle
- mem_rvalid  in  1  read data valid; never in the same cycle as the read's mem_ready
- mem_rdata  in  DATA_W  read data

## Operation
- Write path: MemWrite with buffer not full → entry pushed at the clock edge, Stall=0 (no wait). MemWrite with buffer full → Stall=1 until a slot frees. A pop in the same cycle does not un-stall; the push happens the following cycle.
- Drain: when the read FSM does not own the port and the buffer is not empty, the head entry is issued with mem_we=1. The entry pops on mem_ready. One transaction is outstanding at a time.
- Read FSM states: IDLE, RD_HIT, RD_DRAIN, RD_REQ, RD_WAIT, RD_DONE.
  - IDLE + MemRead: address match in the buffer → RD_HIT, latching the youngest matching entry's data. Otherwise, buffer empty and no write in flight → RD_REQ. Otherwise → RD_DRAIN.
  - RD_HIT → RD_DONE.
  - RD_DRAIN → RD_REQ once the buffer is empty and the last write is accepted.
  - RD_REQ (mem_req=1, mem_we=0) → RD_WAIT on mem_ready.
  - RD_WAIT → RD_DONE on mem_rvalid, capturing mem_rdata.
  - RD_DONE → IDLE.
- Stall = (MemRead & state≠RD_DONE) | (MemWrite & full). Stall is combinational from state, request and full.
- MemoryOut holds the last captured read data; it is 0 after reset.
- MemRead and MemWrite high together is illegal. The bridge treats it as a write and ignores the read. The bench flags it with an assertion.
- Reset mid-operation: the buffer is flushed, the FSM returns to IDLE and any outstanding memory transaction is abandoned. The memory model must tolerate this.

## Timing
- Reset values: Stall=0 with no request, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, MemoryOut=0. Buffer empty; state IDLE.
- All memory-side outputs are registered.
- The earliest mem_req for a pushed write is the cycle after the push.
- Read hit: Stall=1 for 2 cycles (IDLE, RD_HIT), data in the RD_DONE cycle.
- Read miss, empty buffer, memory with mem_ready in the RD_REQ cycle and mem_rvalid one cycle later: Stall=1 for 3 cycles, data in cycle 4.
- Each memory wait cycle adds one stall cycle.
- Buffer pointers are ADDR log2(WBUF_DEPTH)+1 bits wide and wrap modulo 2·WBUF_DEPTH. full is asserted when the low bits are equal and the MSBs differ. empty is asserted when the pointers are equal.

## Structure
- Shared package cpu_mem_pkg holds:
  - the read-FSM state enum;
  - default width and depth constants;
  - the clog2-derived pointer-width constant.
- Sub-module wbuf_fifo holds the write buffer:
  - storage;
  - push and pop logic;
  - full and empty flags;
  - a parallel address compare returning hit and youngest-match data.
- The bridge top holds the read FSM, the drain logic and the port mux.

## Test plan
- Reset and writes: after reset, issue writes A=0x10 and B=0x14 (data 0xAAAA, 0xBBBB), memory ready=1.
  - Stall stays 0 for both writes.
  - Two mem_we=1 transactions appear in order, first in the cycle after the push.
- Full buffer: memory ready held 0, 5 writes with WBUF_DEPTH=4.
  - Fifth write sees Stall=1.
  - Raising ready pops the head; the fifth write is pushed one cycle later.
- Forwarding: writes 0x20←1 then 0x20←2, then read 0x20, ready=0.
  - MemoryOut=2 after 2 stall cycles.
  - No read request reaches memory.
- Ordering: write 0x30←7, then immediate read of 0x40, ready delayed 3 cycles.
  - Read request is issued only after the write is accepted.
  - Returned mem_rdata 0x5 appears on MemoryOut.
- Zero-wait read miss: empty buffer, ready=1, rvalid one cycle later with 0xDEAD.
  - Exactly 3 stall cycles, then MemoryOut=0xDEAD.
- Reset mid-read: assert rst during RD_WAIT.
  - All outputs return to reset values immediately and the buffer is empty.
  - A subsequent read completes normally.
